hl1_hblur3: RTL and testbench
=============================

# hl1_hblur3

Horizontal 3-tap [1 2 1]/4 smoothing stage for the visual-saliency pipeline. It sits directly downstream of the HL1 pass-through actor and consumes its 16-bit Out1 token stream. Rows have fixed width `IMG_WIDTH`, and the left and right image edges use replicate padding. It emits one smoothed 16-bit token per input pixel and uses the same In1/Out1 token-port convention as the other actors, so it drops in between HL1 and the next stage.

## Interface
- `IMG_WIDTH`, default 512: pixels per row. Legal range is 2..65535.
- `CLK` input 1: single clock. All state updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `In1_DATA` input 16: unsigned pixel from HL1.
- `In1_SEND` input 1: upstream has a token available.
- `In1_ACK` output 1: token consumed this cycle.
- `In1_COUNT` input 16: ignored. Tokens are always single.
- `Out1_DATA` output 16: smoothed pixel.
- `Out1_SEND` output 1: token transferred this cycle.
- `Out1_RDY` input 1: downstream can accept a token this cycle.
- `Out1_ACK` input 1: ignored. Kept for port compatibility.
- `Out1_COUNT` output 16: constant 16'h1.

## Operation
- Row notation: pixels p0..p(W-1), where W = `IMG_WIDTH`. Output o_i = (p_{i-1} + 2·p_i + p_{i+1} + R) >> 2.
  - Edge padding: p_{-1} = p0 and p_W = p(W-1).
  - R is the rounding constant; see Configuration.
- Datapath registers:
  - `a` holds p_{i-1}; `b` holds p_i.
  - The sum is 18 bits wide and cannot overflow. The shifted result always fits in 16 bits, so no saturation is needed.
- Output register `ov` (valid) / `od` (data):
  - `Out1_SEND = ov & Out1_RDY`.
  - `Out1_DATA = od`.
  - `ov` clears on transfer unless it is reloaded in the same cycle.
- `slot_free = ~ov | Out1_RDY`.
- Column counter `col`: 16 bits, counts 0..W-1.
- States:
  - FILL:
    - `In1_ACK = In1_SEND`. No output is produced.
    - On accept of p: `a <= p`, `b <= p`, `col <= 1`, go to RUN.
  - RUN:
    - `In1_ACK = In1_SEND & slot_free`.
    - On accept of p: `od <= (a + 2b + p + R) >> 2`, `ov <= 1`, `a <= b`, `b <= p`, `col <= col + 1`.
    - If `col == W-1` at accept, go to FLUSH; otherwise stay in RUN.
  - FLUSH:
    - `In1_ACK = 0`.
    - When `slot_free`: `od <= (a + 3b + R) >> 2`, `ov <= 1`, `col <= 0`, go to FILL.
- Row boundaries come only from `col`. There is no sideband end-of-row signal.

## Timing
- Reset values:
  - State FILL, `col = 0`, `a = b = 0`, `ov = 0`, `od = 0`.
  - Outputs: `Out1_DATA = 0`, `Out1_SEND = 0`, `In1_ACK = 0` unless `In1_SEND` is high while in FILL.
  - `Out1_COUNT = 1` at all times.
- `In1_ACK` and `Out1_SEND` are combinational. A transfer occurs in the same cycle the signal is high.
- Latency:
  - o_i for i < W-1 is presented in the cycle after p_{i+1} is accepted.
  - o(W-1) is presented in the cycle after FLUSH is entered, provided the slot is free.
- Throughput:
  - One token per cycle while `Out1_RDY` stays high.
  - Each row costs W+1 cycles: FILL produces no output and FLUSH accepts no input.
- Simultaneous events:
  - An output transfer and an `od` reload in the same cycle are legal. The new value is valid the next cycle with no bubble.
- Backpressure:
  - With `Out1_RDY` low and `ov` high, `In1_ACK` is held at 0.
  - Exactly one result is buffered. No token is lost or duplicated.
- Reset mid-row: all partial-row state is discarded. The next accepted token is treated as p0.
- W = 2: FILL, then RUN (one accept, which goes straight to FLUSH), then FLUSH.

## Configuration
- `HL1_HBLUR3_ROUND_EN`:
  - Defined: R = 2, giving round-half-up.
  - Undefined: R = 0, giving a truncating shift.
- No other behaviour differs between the two builds.

## Test plan
- Constant row 100,100,100,100 (W=4), `Out1_RDY` held at 1 → outputs 100,100,100,100. `In1_ACK` is 0 for exactly one cycle at the row end.
- Ramp row 0,4,8,12 (W=4), either build → outputs 1,4,8,11.
- Row 0,0,3,0 (W=4):
  - With the macro defined → outputs 0,1,2,1.
  - Without the macro → outputs 0,0,1,0.
- Row of all 16'hFFFF (W=8) → every output is 16'hFFFF in both builds.
- Backpressure, W=4, row 10,20,30,40:
  - Drop `Out1_RDY` after the first output.
  - Required: `In1_ACK` = 0 while `Out1_RDY` is low, and `Out1_DATA` is held.
  - On release, outputs continue in order 13,20,30,38 (macro defined) with none lost.
- Reset mid-row: assert `RESET` for 1 cycle after 2 pixels of an 8-pixel row, then send a fresh constant-50 row → all outputs are 50 and exactly 8 are produced.

Source files
------------

// File: rtl/hl1_hblur3.sv
// Horizontal [1 2 1]/4 smoothing with replicate edge padding, one output token per input pixel.
// Define HL1_HBLUR3_ROUND_EN for round-half-up; otherwise the divide by four truncates.
module hl1_hblur3 #(
  parameter int IMG_WIDTH = 512
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] In1_DATA,
  input  logic        In1_SEND,
  output logic        In1_ACK,
  input  logic [15:0] In1_COUNT,
  output logic [15:0] Out1_DATA,
  output logic        Out1_SEND,
  input  logic        Out1_RDY,
  input  logic        Out1_ACK,
  output logic [15:0] Out1_COUNT
);

`ifdef HL1_HBLUR3_ROUND_EN
  localparam logic [17:0] RND = 18'd2;
`else
  localparam logic [17:0] RND = 18'd0;
`endif

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        ov_q, ov_d;
  logic [15:0] od_q, od_d;

  logic        slotFree;
  logic [17:0] runSum;
  logic [17:0] flushSum;
  logic [15:0] runAvg;
  logic [15:0] flushAvg;
  logic        unusedInputs;

  assign unusedInputs = ^{In1_COUNT, Out1_ACK};

  assign slotFree = ~ov_q | Out1_RDY;
  assign runSum   = {2'b00, a_q} + {1'b0, b_q, 1'b0} + {2'b00, In1_DATA} + RND;
  // Right edge replicates the last pixel, so its weight becomes 3.
  assign flushSum = {2'b00, a_q} + {1'b0, b_q, 1'b0} + {2'b00, b_q} + RND;
  assign runAvg   = 16'(runSum >> 2);
  assign flushAvg = 16'(flushSum >> 2);

  assign Out1_DATA  = od_q;
  assign Out1_SEND  = ov_q & Out1_RDY;
  assign Out1_COUNT = 16'h0001;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    a_d     = a_q;
    b_d     = b_q;
    od_d    = od_q;
    ov_d    = ov_q & ~Out1_RDY;
    In1_ACK = 1'b0;
    unique case (state_q)
      FILL: begin
        In1_ACK = In1_SEND;
        if (In1_SEND) begin
          a_d     = In1_DATA;
          b_d     = In1_DATA;
          col_d   = 16'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        In1_ACK = In1_SEND & slotFree;
        if (In1_SEND && slotFree) begin
          od_d  = runAvg;
          ov_d  = 1'b1;
          a_d   = b_q;
          b_d   = In1_DATA;
          col_d = col_q + 16'd1;
          if (col_q == LAST_COL) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slotFree) begin
          od_d    = flushAvg;
          ov_d    = 1'b1;
          col_d   = 16'd0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FILL;
      col_q   <= 16'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      ov_q    <= 1'b0;
      od_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

endmodule

// File: tb/tb_hl1_hblur3.sv
// Scoreboard bench for hl1_hblur3: expected rows come from a row-level [1 2 1]/4 model.
module tb_hl1_hblur3;
  localparam int W = 4;
`ifdef HL1_HBLUR3_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] In1_DATA = 16'd0;
  logic        In1_SEND = 1'b0;
  logic        In1_ACK;
  logic [15:0] In1_COUNT = 16'd1;
  logic [15:0] Out1_DATA;
  logic        Out1_SEND;
  logic        Out1_RDY = 1'b1;
  logic        Out1_ACK = 1'b0;
  logic [15:0] Out1_COUNT;

  int checks = 0;
  int failures = 0;
  int outCount = 0;
  int expTotal = 0;
  int stallCount = 0;
  bit rdyRandom = 1'b0;
  int expQ[$];
  int rowBuf[W];

  hl1_hblur3 #(.IMG_WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET),
    .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_ACK(In1_ACK), .In1_COUNT(In1_COUNT),
    .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK),
    .Out1_COUNT(Out1_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Replicate-padded [1 2 1]/4 over the row held in rowBuf.
  function automatic int modelOut(input int i);
    int left, right;
    left  = (i == 0) ? rowBuf[0] : rowBuf[i-1];
    right = (i == W-1) ? rowBuf[W-1] : rowBuf[i+1];
    return (left + 2*rowBuf[i] + right + RND) / 4;
  endfunction

  task automatic pushExpected();
    for (int i = 0; i < W; i++) begin
      expQ.push_back(modelOut(i));
      expTotal++;
    end
  endtask

  // Every output transfer is matched in order against the scoreboard queue.
  always @(negedge CLK) begin
    if (!RESET && Out1_SEND) begin
      outCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", int'(Out1_DATA), -1);
      end else begin
        checkOutput("out_data", int'(Out1_DATA), expQ.pop_front());
      end
    end
    if (!RESET && In1_SEND && !In1_ACK) stallCount++;
  end

  // Random downstream readiness when enabled.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rdyRandom) Out1_RDY = ($urandom_range(0, 2) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept, leaving In1_SEND high.
  task automatic applyStimulus(input int p);
    int waitCycles;
    waitCycles = 0;
    In1_DATA = 16'(p);
    In1_SEND = 1'b1;
    @(negedge CLK);
    while (!In1_ACK && waitCycles < 500) begin
      waitCycles++;
      @(negedge CLK);
    end
    if (!In1_ACK) checkOutput("accept_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    In1_SEND = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic sendRow(input bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      applyStimulus(rowBuf[i]);
    end
    In1_SEND = 1'b0;
  endtask

  task automatic drain();
    int waitCycles;
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 2000) begin
      waitCycles++;
      @(posedge CLK);
      #1;
    end
    checkOutput("drain_pending", expQ.size(), 0);
    idle(3);
  endtask

  task automatic setRow(input int v0, input int v1, input int v2, input int v3);
    rowBuf[0] = v0; rowBuf[1] = v1; rowBuf[2] = v2; rowBuf[3] = v3;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int held;
    int countBefore;
    repeat (3) @(posedge CLK);
    #1;
    In1_SEND = 1'b1;
    @(negedge CLK);
    checkOutput("ack_in_fill", int'(In1_ACK), 1);
    @(posedge CLK);
    #1;
    In1_SEND = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("reset_data", int'(Out1_DATA), 0);
    checkOutput("reset_send", int'(Out1_SEND), 0);
    checkOutput("reset_ack", int'(In1_ACK), 0);
    checkOutput("count_const", int'(Out1_COUNT), 1);
    @(posedge CLK);
    #1;

    // Two back-to-back constant rows: only the first row end stalls the input.
    setRow(100, 100, 100, 100);
    pushExpected();
    pushExpected();
    stallCount = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < W; i++) applyStimulus(rowBuf[i]);
    In1_SEND = 1'b0;
    checkOutput("row_end_stall", stallCount, 1);
    drain();

    setRow(0, 4, 8, 12);
    pushExpected();
    sendRow(1'b0);
    drain();

    setRow(0, 0, 3, 0);
    pushExpected();
    sendRow(1'b0);
    drain();

    setRow(65535, 65535, 65535, 65535);
    pushExpected();
    sendRow(1'b0);
    drain();

    // Backpressure after the first output.
    setRow(10, 20, 30, 40);
    pushExpected();
    applyStimulus(10);
    applyStimulus(20);
    applyStimulus(30);
    Out1_RDY = 1'b0;
    In1_DATA = 16'd40;
    In1_SEND = 1'b1;
    @(negedge CLK);
    held = int'(Out1_DATA);
    checkOutput("bp_held_model", held, modelOut(1));
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_ack_low", int'(In1_ACK), 0);
      checkOutput("bp_data_held", int'(Out1_DATA), held);
      @(posedge CLK);
      #1;
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    Out1_RDY = 1'b1;
    applyStimulus(40);
    In1_SEND = 1'b0;
    drain();

    // Reset mid-row with the output held so nothing of the partial row escapes.
    Out1_RDY = 1'b0;
    applyStimulus(7);
    applyStimulus(900);
    In1_SEND = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    Out1_RDY = 1'b1;
    @(negedge CLK);
    checkOutput("midreset_send", int'(Out1_SEND), 0);
    @(posedge CLK);
    #1;
    countBefore = outCount;
    setRow(50, 50, 50, 50);
    pushExpected();
    sendRow(1'b0);
    drain();
    checkOutput("midreset_count", outCount - countBefore, W);

    // Random rows with random gaps and random downstream readiness.
    rdyRandom = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < W; i++) begin
        case ($urandom_range(0, 5))
          0: rowBuf[i] = 65535;
          1: rowBuf[i] = 0;
          2: rowBuf[i] = $urandom_range(0, 7);
          default: rowBuf[i] = $urandom_range(0, 65535);
        endcase
      end
      pushExpected();
      sendRow(1'b1);
    end
    drain();
    rdyRandom = 1'b0;
    @(posedge CLK);
    #1;
    Out1_RDY = 1'b1;
    idle(4);

    checkOutput("total_outputs", outCount, expTotal);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("count_end", int'(Out1_COUNT), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
